player_ctrl: RTL and testbench
==============================

Name: player_ctrl

Overview:
- Converts one player's held-key levels (up/down/left/right/drop from the PS/2 keyboard decoder) into tile-to-tile movement on the arena grid.
- Each step checks the target tile against the map store through a request/ack handshake before moving.
- Issues bomb-drop requests with a frame-based cooldown.
- Sits between the keyboard decoder and the game map / sprite renderer; instantiated once per player.

Parameters:
- GRID_W, 15, arena width in tiles; columns 0..GRID_W-1.
- GRID_H, 13, arena height in tiles; rows 0..GRID_H-1.
- TILE, 32, tile size in pixels; power of two.
- STEP, 2, pixels advanced per frame_tick; must divide TILE.
- X_OFF, 64, pixel x of column 0.
- Y_OFF, 32, pixel y of row 0.
- COL_INIT, 1, spawn column.
- ROW_INIT, 1, spawn row.
- DROP_COOLDOWN, 30, frames between accepted drops.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- key_up, key_down, key_left, key_right, key_drop  in  1 each  held-key levels, synchronous to clk
- kill  in  1  one-cycle pulse: player hit by blast
- map_req  out  1  tile query request
- map_col  out  4  queried column
- map_row  out  4  queried row
- map_ack  in  1  one-cycle query response strobe
- map_free  in  1  queried tile walkable; valid with map_ack
- pos_x  out  10  sprite pixel x
- pos_y  out  9  sprite pixel y
- tile_col  out  4  current tile column
- tile_row  out  4  current tile row
- facing  out  2  last direction: 0 up, 1 down, 2 left, 3 right
- moving  out  1  high in MOVE state
- alive  out  1  low in DEAD state
- bomb_req  out  1  one-cycle drop pulse
- bomb_col  out  4  drop column, valid with bomb_req
- bomb_row  out  4  drop row, valid with bomb_req

Behaviour:
- Reset (async) values:
  - state IDLE; tile_col=COL_INIT, tile_row=ROW_INIT; offset=0.
  - facing=1; alive=1; moving=0; map_req=0; bomb_req=0; cooldown=0.
  - pos_x = X_OFF + COL_INIT*TILE; pos_y = Y_OFF + ROW_INIT*TILE.
  - Reset mid-move or mid-query aborts everything and returns to spawn.
- Direction select: priority up > down > left > right. Lower-priority keys held together with a higher one are ignored.
- IDLE:
  - If any direction is held, latch dir, set facing=dir, compute target = current tile ±1.
  - Target outside 0..GRID_W-1 / 0..GRID_H-1: stay IDLE, no request; facing still updates.
  - Otherwise next cycle go to QUERY with map_req=1 and map_col/map_row = target.
- QUERY:
  - map_req and address are held stable until map_ack; no timeout.
  - On map_ack: map_req=0 on the next edge. map_free=1 -> MOVE; map_free=0 -> IDLE.
  - Key changes during QUERY are ignored.
- MOVE:
  - moving=1. On each frame_tick, offset += STEP.
  - When offset reaches TILE: tile_col/tile_row = target, offset=0, go IDLE in the same edge.
  - Key release does not stop the move; the player always completes the tile.
  - A held key re-queries in the cycle after IDLE is entered, giving continuous motion with a 1 + map-latency cycle gap (well inside a frame).
- Position: offset is applied signed along dir.
  - Left: pos_x = X_OFF + tile_col*TILE - offset. Up is analogous on y.
  - Registered, updated the cycle after offset/tile change.
- Drop:
  - Rising edge of key_drop (registered previous value) with cooldown==0 and alive=1 -> bomb_req=1 for exactly one cycle; cooldown=DROP_COOLDOWN.
  - Bomb tile = current tile if offset < TILE/2, else target tile.
  - Drop is accepted in any of IDLE/QUERY/MOVE and does not alter the movement state.
  - cooldown decrements on frame_tick, saturating at 0.
  - Edges during cooldown are discarded, not queued.
- kill:
  - From any state -> DEAD next edge: alive=0, moving=0, map_req=0, bomb_req suppressed. Position is frozen.
  - A kill coinciding with map_ack or a drop edge takes priority.
  - DEAD is left only by reset.
- frame_tick coinciding with the entry cycle into MOVE counts as a step.

Test Plan:
- Move right into a free tile: reset, hold key_right, ack map_free=1 after 3 cycles → map_col=2/map_row=1 requested; 16 frame_ticks later tile_col=2, pos_x=128; moving drops.
- Wall and boundary: hold key_up at row 0 (spawn override) → no map_req, facing=0. Hold key_left with map_free=0 → back to IDLE, pos unchanged.
- Priority and release: hold key_up+key_right → query targets row 0 col 1. Release at offset 10 → motion completes to offset 32, then idle.
- Drop and cooldown: press drop at offset 14 moving right from col 1 → bomb_req with bomb_col=1. Second press 10 frames later → ignored. Press at 31 frames → accepted.
- Drop past half: press drop at offset 16 moving right → bomb_col=2.
- Kill during QUERY: kill with map_req high → map_req=0 next edge, alive=0; later map_ack and keys have no effect; reset_n low restores spawn (pos 96,64).

Source files
------------

// File: rtl/player_ctrl.sv
// player_ctrl: turns one player's held-key levels into tile-to-tile movement.
// Each step asks the map store whether the target tile is walkable over a
// req/ack handshake, then slides the sprite STEP pixels per frame until the
// tile is reached. Also issues bomb-drop pulses with a frame-based cooldown.
//
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   frame_tick                     one-cycle pulse per video frame
//   key_up/down/left/right/drop    held-key levels (clk domain)
//   kill                           one-cycle pulse, player hit by blast
//   map_req, map_col, map_row      tile query request and address
//   map_ack, map_free              query response strobe and walkable flag
//   pos_x, pos_y                   sprite pixel position
//   tile_col, tile_row             current tile
//   facing                         last direction (0 up, 1 down, 2 left, 3 right)
//   moving, alive                  status
//   bomb_req, bomb_col, bomb_row   one-cycle drop pulse and drop tile
//
// state | meaning
// IDLE  | standing on a tile, waiting for a direction key
// QUERY | map_req held, waiting for map_ack on the target tile
// MOVE  | sliding toward the target tile on frame_tick
// DEAD  | killed; everything frozen until reset
module player_ctrl #(
  parameter int GRID_W        = 15,
  parameter int GRID_H        = 13,
  parameter int TILE          = 32,
  parameter int STEP          = 2,
  parameter int X_OFF         = 64,
  parameter int Y_OFF         = 32,
  parameter int COL_INIT      = 1,
  parameter int ROW_INIT      = 1,
  parameter int DROP_COOLDOWN = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_drop,
  input  logic       kill,
  output logic       map_req,
  output logic [3:0] map_col,
  output logic [3:0] map_row,
  input  logic       map_ack,
  input  logic       map_free,
  output logic [9:0] pos_x,
  output logic [8:0] pos_y,
  output logic [3:0] tile_col,
  output logic [3:0] tile_row,
  output logic [1:0] facing,
  output logic       moving,
  output logic       alive,
  output logic       bomb_req,
  output logic [3:0] bomb_col,
  output logic [3:0] bomb_row
);

  localparam int TILE_SH = $clog2(TILE);
  localparam int OFF_W   = TILE_SH + 1;
  localparam int CD_W    = $clog2(DROP_COOLDOWN + 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_QUERY, S_MOVE, S_DEAD} state_t;

  state_t           state_q, state_d;
  logic [3:0]       col_q, col_d, row_q, row_d;
  logic [OFF_W-1:0] off_q, off_d, off_next;
  logic [1:0]       facing_q, facing_d;
  logic             map_req_q, map_req_d;
  logic [3:0]       map_col_q, map_col_d, map_row_q, map_row_d;
  logic             moving_q, moving_d;
  logic             alive_q, alive_d;
  logic             bomb_req_q, bomb_req_d;
  logic [3:0]       bomb_col_q, bomb_col_d, bomb_row_q, bomb_row_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic             drop_prev_q, drop_prev_d;
  logic [9:0]       pos_x_q, pos_x_d, base_x, off_x;
  logic [8:0]       pos_y_q, pos_y_d, base_y, off_y;

  logic             dir_valid;
  logic [1:0]       dir;
  logic             tgt_ok;
  logic [3:0]       tgt_col, tgt_row;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    off_d       = off_q;
    facing_d    = facing_q;
    map_req_d   = map_req_q;
    map_col_d   = map_col_q;
    map_row_d   = map_row_q;
    moving_d    = moving_q;
    alive_d     = alive_q;
    bomb_req_d  = 1'b0;
    bomb_col_d  = bomb_col_q;
    bomb_row_d  = bomb_row_q;
    cd_d        = cd_q;
    drop_prev_d = key_drop;
    off_next    = off_q + OFF_W'(STEP);

    // Sprite position trails tile/offset by one cycle; offset is signed along facing.
    base_x = 10'(X_OFF) + (10'(col_q) << TILE_SH);
    base_y = 9'(Y_OFF) + (9'(row_q) << TILE_SH);
    off_x  = 10'(off_q);
    off_y  = 9'(off_q);
    pos_x_d = base_x;
    pos_y_d = base_y;
    case (facing_q)
      DIR_RIGHT: pos_x_d = base_x + off_x;
      DIR_LEFT:  pos_x_d = base_x - off_x;
      DIR_DOWN:  pos_y_d = base_y + off_y;
      default:   pos_y_d = base_y - off_y;
    endcase

    // Fixed priority: up > down > left > right.
    dir_valid = key_up | key_down | key_left | key_right;
    dir       = DIR_RIGHT;
    tgt_col   = col_q;
    tgt_row   = row_q;
    tgt_ok    = 1'b0;
    if (key_up) begin
      dir     = DIR_UP;
      tgt_row = row_q - 4'd1;
      tgt_ok  = (row_q != 4'd0);
    end else if (key_down) begin
      dir     = DIR_DOWN;
      tgt_row = row_q + 4'd1;
      tgt_ok  = (row_q < 4'(GRID_H - 1));
    end else if (key_left) begin
      dir     = DIR_LEFT;
      tgt_col = col_q - 4'd1;
      tgt_ok  = (col_q != 4'd0);
    end else if (key_right) begin
      dir     = DIR_RIGHT;
      tgt_col = col_q + 4'd1;
      tgt_ok  = (col_q < 4'(GRID_W - 1));
    end

    if (frame_tick && cd_q != '0) cd_d = cd_q - 1'b1;

    case (state_q)
      S_IDLE: begin
        if (dir_valid) begin
          facing_d = dir;
          if (tgt_ok) begin
            state_d   = S_QUERY;
            map_req_d = 1'b1;
            map_col_d = tgt_col;
            map_row_d = tgt_row;
          end
        end
      end
      S_QUERY: begin
        if (map_ack) begin
          map_req_d = 1'b0;
          if (map_free) begin
            state_d  = S_MOVE;
            moving_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_MOVE: begin
        if (frame_tick) begin
          if (off_next == OFF_W'(TILE)) begin
            col_d    = map_col_q;
            row_d    = map_row_q;
            off_d    = '0;
            state_d  = S_IDLE;
            moving_d = 1'b0;
          end else begin
            off_d = off_next;
          end
        end
      end
      default: ;
    endcase

    // Drop works in any live state; map_col/map_row hold the target while moving.
    if (key_drop && !drop_prev_q && cd_q == '0 && state_q != S_DEAD && !kill) begin
      bomb_req_d = 1'b1;
      cd_d       = CD_W'(DROP_COOLDOWN);
      if (off_q < OFF_W'(TILE / 2)) begin
        bomb_col_d = col_q;
        bomb_row_d = row_q;
      end else begin
        bomb_col_d = map_col_q;
        bomb_row_d = map_row_q;
      end
    end

    // Kill overrides any movement or handshake outcome from the same cycle.
    if (kill) begin
      state_d   = S_DEAD;
      alive_d   = 1'b0;
      moving_d  = 1'b0;
      map_req_d = 1'b0;
      col_d     = col_q;
      row_d     = row_q;
      off_d     = off_q;
      facing_d  = facing_q;
      map_col_d = map_col_q;
      map_row_d = map_row_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      col_q       <= 4'(COL_INIT);
      row_q       <= 4'(ROW_INIT);
      off_q       <= '0;
      facing_q    <= DIR_DOWN;
      map_req_q   <= 1'b0;
      map_col_q   <= 4'(COL_INIT);
      map_row_q   <= 4'(ROW_INIT);
      moving_q    <= 1'b0;
      alive_q     <= 1'b1;
      bomb_req_q  <= 1'b0;
      bomb_col_q  <= 4'd0;
      bomb_row_q  <= 4'd0;
      cd_q        <= '0;
      drop_prev_q <= 1'b0;
      pos_x_q     <= 10'(X_OFF + COL_INIT * TILE);
      pos_y_q     <= 9'(Y_OFF + ROW_INIT * TILE);
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      off_q       <= off_d;
      facing_q    <= facing_d;
      map_req_q   <= map_req_d;
      map_col_q   <= map_col_d;
      map_row_q   <= map_row_d;
      moving_q    <= moving_d;
      alive_q     <= alive_d;
      bomb_req_q  <= bomb_req_d;
      bomb_col_q  <= bomb_col_d;
      bomb_row_q  <= bomb_row_d;
      cd_q        <= cd_d;
      drop_prev_q <= drop_prev_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
    end
  end

  assign map_req  = map_req_q;
  assign map_col  = map_col_q;
  assign map_row  = map_row_q;
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign tile_col = col_q;
  assign tile_row = row_q;
  assign facing   = facing_q;
  assign moving   = moving_q;
  assign alive    = alive_q;
  assign bomb_req = bomb_req_q;
  assign bomb_col = bomb_col_q;
  assign bomb_row = bomb_row_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with a behavioural reference model checked
// every cycle, plus hand-computed literal checks along the scenario.
module tb_player_ctrl;
  localparam int GRID_W = 15, GRID_H = 13, TILE = 32, STEP = 2;
  localparam int X_OFF = 64, Y_OFF = 32, COL_INIT = 1, ROW_INIT = 1, COOL = 30;

  logic clk = 0, reset_n = 0;
  logic frame_tick = 0, key_up = 0, key_down = 0, key_left = 0, key_right = 0, key_drop = 0;
  logic kill = 0, map_ack = 0, map_free = 0;
  logic map_req, moving, alive, bomb_req;
  logic [3:0] map_col, map_row, tile_col, tile_row, bomb_col, bomb_row;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  logic [1:0] facing;

  int total = 0, bad = 0;

  player_ctrl dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_drop(key_drop), .kill(kill),
    .map_req(map_req), .map_col(map_col), .map_row(map_row),
    .map_ack(map_ack), .map_free(map_free),
    .pos_x(pos_x), .pos_y(pos_y), .tile_col(tile_col), .tile_row(tile_row),
    .facing(facing), .moving(moving), .alive(alive),
    .bomb_req(bomb_req), .bomb_col(bomb_col), .bomb_row(bomb_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: player described as tile coordinates, a signed pixel
  // offset and three flags (querying / walking / dead).
  int m_col = COL_INIT, m_row = ROW_INIT, m_off = 0, m_tc = COL_INIT, m_tr = ROW_INIT;
  int m_face = 1, m_cd = 0, m_bc = 0, m_br = 0;
  int m_px = X_OFF + COL_INIT * TILE, m_py = Y_OFF + ROW_INIT * TILE;
  bit m_q = 0, m_mv = 0, m_dead = 0, m_breq = 0, m_prev = 0;

  always @(posedge clk or negedge reset_n) begin
    int d, tc, tr;
    bit press;
    if (!reset_n) begin
      m_col = COL_INIT; m_row = ROW_INIT; m_off = 0; m_tc = COL_INIT; m_tr = ROW_INIT;
      m_face = 1; m_cd = 0; m_q = 0; m_mv = 0; m_dead = 0; m_breq = 0; m_prev = 0;
      m_px = X_OFF + COL_INIT * TILE; m_py = Y_OFF + ROW_INIT * TILE;
    end else begin
      m_px = X_OFF + m_col * TILE + (m_face == 3 ? m_off : (m_face == 2 ? -m_off : 0));
      m_py = Y_OFF + m_row * TILE + (m_face == 1 ? m_off : (m_face == 0 ? -m_off : 0));
      press = key_drop && !m_prev;
      m_prev = key_drop;
      m_breq = 0;
      if (kill || m_dead) begin
        m_dead = 1; m_q = 0; m_mv = 0;
        if (frame_tick && m_cd > 0) m_cd--;
      end else begin
        if (press && m_cd == 0) begin
          m_breq = 1;
          m_cd = COOL;
          m_bc = (m_off < TILE / 2) ? m_col : m_tc;
          m_br = (m_off < TILE / 2) ? m_row : m_tr;
        end else if (frame_tick && m_cd > 0) m_cd--;
        if (!m_q && !m_mv) begin
          d = key_up ? 0 : key_down ? 1 : key_left ? 2 : key_right ? 3 : -1;
          if (d >= 0) begin
            m_face = d;
            tc = m_col + (d == 3 ? 1 : 0) - (d == 2 ? 1 : 0);
            tr = m_row + (d == 1 ? 1 : 0) - (d == 0 ? 1 : 0);
            if (tc >= 0 && tc < GRID_W && tr >= 0 && tr < GRID_H) begin
              m_q = 1; m_tc = tc; m_tr = tr;
            end
          end
        end else if (m_q) begin
          if (map_ack) begin m_q = 0; m_mv = map_free; end
        end else if (frame_tick) begin
          m_off += STEP;
          if (m_off == TILE) begin
            m_col = m_tc; m_row = m_tr; m_off = 0; m_mv = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("alive", alive, !m_dead);
      chk("moving", moving, m_mv);
      chk("map_req", map_req, m_q);
      chk("tile_col", tile_col, m_col);
      chk("tile_row", tile_row, m_row);
      chk("facing", facing, m_face);
      chk("pos_x", pos_x, m_px);
      chk("pos_y", pos_y, m_py);
      chk("bomb_req", bomb_req, m_breq);
      if (m_q) begin
        chk("map_col", map_col, m_tc);
        chk("map_row", map_row, m_tr);
      end
      if (m_breq) begin
        chk("bomb_col", bomb_col, m_bc);
        chk("bomb_row", bomb_row, m_br);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1; @(negedge clk);
      frame_tick = 0; cyc(3);
    end
  endtask

  task automatic wait_req();
    int k = 0;
    while (!map_req && k < 50) begin @(negedge clk); k++; end
    if (!map_req) chk("req_timeout", 0, 1);
  endtask

  task automatic ack(input int lat, input bit free);
    cyc(lat);
    map_ack = 1; map_free = free; @(negedge clk);
    map_ack = 0; map_free = 0;
  endtask

  initial begin
    cyc(2);
    reset_n = 1;
    cyc(1);
    chk("rst_pos_x", pos_x, 96);
    chk("rst_pos_y", pos_y, 64);
    chk("rst_facing", facing, 1);
    chk("rst_alive", alive, 1);
    chk("rst_map_req", map_req, 0);

    // Move right (1,1) -> (2,1)
    key_right = 1;
    wait_req();
    chk("r_map_col", map_col, 2);
    chk("r_map_row", map_row, 1);
    key_right = 0;
    ack(3, 1);
    frames(16);
    chk("r_tile_col", tile_col, 2);
    chk("r_pos_x", pos_x, 128);
    chk("r_moving", moving, 0);

    // Up+right: up wins, release at offset 10, move completes
    key_up = 1; key_right = 1;
    wait_req();
    chk("u_map_row", map_row, 0);
    chk("u_map_col", map_col, 2);
    ack(1, 1);
    frames(5);
    key_up = 0; key_right = 0;
    chk("u_pos_y_mid", pos_y, 54);
    chk("u_moving_mid", moving, 1);
    frames(11);
    chk("u_tile_row", tile_row, 0);
    chk("u_pos_y", pos_y, 32);

    // Left into a wall
    key_left = 1;
    wait_req();
    chk("l_map_col", map_col, 1);
    key_left = 0;
    ack(1, 0);
    cyc(3);
    chk("l_pos_x", pos_x, 128);
    chk("l_moving", moving, 0);
    chk("l_facing", facing, 2);

    // Up at row 0: no request, facing still updates
    key_up = 1;
    cyc(5);
    chk("b_map_req", map_req, 0);
    chk("b_facing", facing, 0);
    key_up = 0;

    // Drop at offset 14 moving right from col 2, then cooldown
    key_right = 1;
    wait_req();
    key_right = 0;
    ack(1, 1);
    frames(7);
    key_drop = 1; @(negedge clk);
    chk("d1_req", bomb_req, 1);
    chk("d1_col", bomb_col, 2);
    @(negedge clk);
    chk("d1_pulse", bomb_req, 0);
    key_drop = 0;
    frames(10);
    key_drop = 1; @(negedge clk);
    chk("d2_ignored", bomb_req, 0);
    key_drop = 0;
    frames(20);

    // Drop at offset 16 moving right from col 3 -> target tile
    key_right = 1;
    wait_req();
    key_right = 0;
    ack(1, 1);
    frames(8);
    key_drop = 1; @(negedge clk);
    chk("d3_req", bomb_req, 1);
    chk("d3_col", bomb_col, 4);
    key_drop = 0;
    frames(8);
    chk("d3_pos_x", pos_x, 192);

    // Kill during QUERY
    key_down = 1;
    wait_req();
    chk("k_map_row", map_row, 1);
    kill = 1; @(negedge clk);
    kill = 0; key_down = 0;
    chk("k_map_req", map_req, 0);
    chk("k_alive", alive, 0);
    ack(1, 1);
    key_right = 1;
    frames(3);
    key_drop = 1; cyc(2);
    key_drop = 0; key_right = 0;
    chk("k_moving", moving, 0);
    chk("k_tile_col", tile_col, 4);
    chk("k_pos_x", pos_x, 192);

    reset_n = 0; #1;
    chk("rr_pos_x", pos_x, 96);
    chk("rr_pos_y", pos_y, 64);
    chk("rr_alive", alive, 1);
    @(negedge clk);
    reset_n = 1;
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
